// File: rtl/div_share_arbiter.sv
// Round-robin sequencer sharing one multi-cycle divider between requesters A and B.
// Accept-to-Div_Go is 1 cycle, result valid 1 cycle after Div_Done; held until the owner's ready.
module div_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqA_Valid,
    input  logic             ReqB_Valid,
    output logic             ReqA_Ready,
    output logic             ReqB_Ready,
    input  logic [WIDTH-1:0] ReqA_Divisor,
    input  logic [WIDTH-1:0] ReqA_Dividend,
    input  logic [WIDTH-1:0] ReqB_Divisor,
    input  logic [WIDTH-1:0] ReqB_Dividend,
    output logic             RespA_Valid,
    output logic             RespB_Valid,
    input  logic             RespA_Ready,
    input  logic             RespB_Ready,
    output logic [WIDTH-1:0] Resp_Quotient,
    output logic [WIDTH-1:0] Resp_Remainder,
    output logic             Resp_DivZero,
    output logic             Resp_Timeout,
    output logic             Div_Go,
    output logic [WIDTH-1:0] Div_Divisor,
    output logic [WIDTH-1:0] Div_Dividend,
    input  logic             Div_Done,
    input  logic [WIDTH-1:0] Div_Quotient,
    input  logic [WIDTH-1:0] Div_Remainder
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;
    logic             r_to;
    logic [7:0]       r_cnt;

    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_go;
    logic             w_vld_a;
    logic             w_vld_b;
    logic [WIDTH-1:0] w_sel_dvs;
    logic [WIDTH-1:0] w_sel_dvd;
    logic [7:0]       w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_go        = 1'b0;
        w_vld_a     = 1'b0;
        w_vld_b     = 1'b0;
        w_sel_dvs   = ReqA_Divisor;
        w_sel_dvd   = ReqA_Dividend;
        case (r_state)
            S_IDLE: begin
                // On a tie the requester that was not served last wins
                w_gnt_a = ReqA_Valid && (!ReqB_Valid || r_last);
                w_gnt_b = ReqB_Valid && (!ReqA_Valid || !r_last);
                if (w_gnt_b) begin
                    w_sel_dvs = ReqB_Divisor;
                    w_sel_dvd = ReqB_Dividend;
                end
                if (w_gnt_a || w_gnt_b) begin
                    w_state_nxt = (w_sel_dvs == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_go        = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (Div_Done || (w_cnt_inc == LP_TIMEOUT)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_vld_a = !r_owner;
                w_vld_b = r_owner;
                if (r_owner ? RespB_Ready : RespA_Ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_dvs   <= '0;
            r_dvd   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_a || w_gnt_b) begin
                        r_owner <= w_gnt_b;
                        r_last  <= w_gnt_b;
                        r_dvs   <= w_sel_dvs;
                        r_dvd   <= w_sel_dvd;
                        if (w_sel_dvs == '0) begin
                            r_q  <= '1;
                            r_r  <= w_sel_dvd;
                            r_dz <= 1'b1;
                            r_to <= 1'b0;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // A done arriving on the expiry cycle still delivers the real result
                    if (Div_Done) begin
                        r_q  <= Div_Quotient;
                        r_r  <= Div_Remainder;
                        r_dz <= 1'b0;
                        r_to <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LP_TIMEOUT) begin
                            r_q  <= '0;
                            r_r  <= '0;
                            r_dz <= 1'b0;
                            r_to <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever state the FSM was in
    assign ReqA_Ready     = w_gnt_a && !Reset;
    assign ReqB_Ready     = w_gnt_b && !Reset;
    assign RespA_Valid    = w_vld_a && !Reset;
    assign RespB_Valid    = w_vld_b && !Reset;
    assign Div_Go         = w_go && !Reset;
    assign Resp_Quotient  = Reset ? '0 : r_q;
    assign Resp_Remainder = Reset ? '0 : r_r;
    assign Resp_DivZero   = r_dz && !Reset;
    assign Resp_Timeout   = r_to && !Reset;
    assign Div_Divisor    = Reset ? '0 : r_dvs;
    assign Div_Dividend   = Reset ? '0 : r_dvd;

endmodule
